// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave receiver.
// The state encoding is the value reported on diag_state.
package spi_pkg;

  localparam int BYTE_BITS   = 8;
  localparam int FRAME_CNT_W = 16;
  localparam int BIT_CNT_W   = $clog2(BYTE_BITS);

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_RECV         = 2'd1,
    ST_WAIT_CS_HIGH = 2'd2
  } state_t;

endpackage

// File: rtl/spi_slave_rx_if.sv
// SPI pins, FIFO write port and status signals of the SPI slave receiver.
// The slave modport is the receiver side; master is the SPI host and FIFO side.
interface spi_slave_rx_if;
  import spi_pkg::*;

  logic                   sclk;
  logic                   cs_n;
  logic                   mosi;
  logic                   fifo_full;
  logic                   ovf_clr;
  logic                   fifo_write;
  logic [BYTE_BITS-1:0]   fifo_wdata;
  logic                   overflow;
  logic                   frame_done;
  logic                   frame_err;
  logic [FRAME_CNT_W-1:0] frame_bytes;
  logic [1:0]             diag_state;

  modport slave (
    input  sclk, cs_n, mosi, fifo_full, ovf_clr,
    output fifo_write, fifo_wdata, overflow, frame_done, frame_err, frame_bytes, diag_state
  );

  modport master (
    output sclk, cs_n, mosi, fifo_full, ovf_clr,
    input  fifo_write, fifo_wdata, overflow, frame_done, frame_err, frame_bytes, diag_state
  );

endinterface

// File: rtl/spi_slave_rx_sync.sv
// Multi-flop synchronizer for one asynchronous input, with rise/fall detection
// on the synchronized level. RST_VAL is the line's idle level.
module spi_sync #(
  parameter int STAGES  = 2,
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic q_reg;
      logic d_in;
      if (gi == 0) begin : g_in
        assign d_in = async_in;
      end else begin : g_chain
        assign d_in = g_stage[gi-1].q_reg;
      end
      always_ff @(posedge clk) begin
        if (rst) q_reg <= RST_VAL;
        else     q_reg <= d_in;
      end
    end
  endgenerate

  logic prev_reg;

  always_ff @(posedge clk) begin
    if (rst) prev_reg <= RST_VAL;
    else     prev_reg <= sync_out;
  end

  assign sync_out = g_stage[STAGES-1].q_reg;
  assign rise     = sync_out & ~prev_reg;
  assign fall     = ~sync_out & prev_reg;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave receiver: assembles bytes from the oversampled SPI pins,
// strobes them into a downstream FIFO and reports per-frame byte counts.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  spi_slave_rx_if.slave  bus
);

  // Sync lanes: 0 = sclk, 1 = cs_n, 2 = mosi; reset to the idle bus levels.
  localparam logic [2:0] SYNC_IDLE = 3'b010;
  localparam int         SETTLE_W  = $clog2(SYNC_STAGES + 1);

  logic [2:0] raw_in;
  logic [2:0] sync_lvl;
  logic [2:0] sync_rise;
  logic [2:0] sync_fall;

  assign raw_in = {bus.mosi, bus.cs_n, bus.sclk};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      spi_sync #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (SYNC_IDLE[gi])
      ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (raw_in[gi]),
        .sync_out (sync_lvl[gi]),
        .rise     (sync_rise[gi]),
        .fall     (sync_fall[gi])
      );
    end
  endgenerate

  logic sclk_rise;
  logic cs_rise;
  logic cs_fall;
  logic cs_lvl;
  logic mosi_lvl;
  logic unused_sync;

  assign sclk_rise   = sync_rise[0];
  assign cs_rise     = sync_rise[1];
  assign cs_fall     = sync_fall[1];
  assign cs_lvl      = sync_lvl[1];
  assign mosi_lvl    = sync_lvl[2];
  assign unused_sync = ^{sync_lvl[0], sync_fall[0], sync_rise[2], sync_fall[2]};

  state_t                 state_reg;
  logic [SETTLE_W-1:0]    settle_reg;
  logic [BIT_CNT_W-1:0]   bit_cnt_reg;
  logic [FRAME_CNT_W-1:0] byte_cnt_reg;
  logic [BYTE_BITS-1:0]   shift_reg;
  logic [BYTE_BITS-1:0]   shift_next;
  logic                   fifo_write_reg;
  logic [BYTE_BITS-1:0]   fifo_wdata_reg;
  logic                   overflow_reg;
  logic                   frame_done_reg;
  logic                   frame_err_reg;
  logic [FRAME_CNT_W-1:0] frame_bytes_reg;
  logic                   settled;
  logic                   byte_done;

  always_comb begin
    shift_next = shift_reg;
    if (MSB_FIRST) shift_next = {shift_reg[BYTE_BITS-2:0], mosi_lvl};
    else           shift_next = {mosi_lvl, shift_reg[BYTE_BITS-1:1]};
  end

  // The synchronizers come out of reset holding idle levels, not real samples;
  // cs_n is trusted only once the chain has been refilled from the pin.
  assign settled   = (settle_reg == SETTLE_W'(SYNC_STAGES));
  assign byte_done = (bit_cnt_reg == BIT_CNT_W'(BYTE_BITS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_WAIT_CS_HIGH;
      settle_reg      <= '0;
      bit_cnt_reg     <= '0;
      byte_cnt_reg    <= '0;
      shift_reg       <= '0;
      fifo_write_reg  <= 1'b0;
      fifo_wdata_reg  <= '0;
      overflow_reg    <= 1'b0;
      frame_done_reg  <= 1'b0;
      frame_err_reg   <= 1'b0;
      frame_bytes_reg <= '0;
    end else begin
      fifo_write_reg <= 1'b0;
      frame_done_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      if (!settled) settle_reg <= settle_reg + 1'b1;
      // A drop later in this block overrides the clear.
      if (bus.ovf_clr) overflow_reg <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (cs_fall) begin
            state_reg    <= ST_RECV;
            bit_cnt_reg  <= '0;
            byte_cnt_reg <= '0;
            shift_reg    <= '0;
          end
        end
        ST_RECV: begin
          if (cs_rise) begin
            state_reg       <= ST_IDLE;
            frame_done_reg  <= 1'b1;
            frame_err_reg   <= (bit_cnt_reg != '0);
            frame_bytes_reg <= byte_cnt_reg;
            bit_cnt_reg     <= '0;
            shift_reg       <= '0;
          end else if (sclk_rise) begin
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            if (byte_done) begin
              if (!bus.fifo_full) begin
                fifo_write_reg <= 1'b1;
                fifo_wdata_reg <= shift_next;
              end else begin
                overflow_reg <= 1'b1;
              end
              if (byte_cnt_reg != '1) byte_cnt_reg <= byte_cnt_reg + 1'b1;
            end
          end
        end
        ST_WAIT_CS_HIGH: begin
          if (settled && cs_lvl) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_WAIT_CS_HIGH;
      endcase
    end
  end

  assign bus.fifo_write  = fifo_write_reg;
  assign bus.fifo_wdata  = fifo_wdata_reg;
  assign bus.overflow    = overflow_reg;
  assign bus.frame_done  = frame_done_reg;
  assign bus.frame_err   = frame_err_reg;
  assign bus.frame_bytes = frame_bytes_reg;
  assign bus.diag_state  = state_reg;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: an MSB-first and an LSB-first instance on shared
// sclk/mosi with separate chip selects, checked against a frame-level model.
module tb_spi_slave_rx;
  import spi_pkg::*;

  localparam int SYNC = 2;
  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic sclk = 1'b0;
  logic mosi = 1'b0;
  logic cs_m_n = 1'b1;
  logic cs_l_n = 1'b1;
  logic fifo_full = 1'b0;
  logic ovf_clr = 1'b0;

  spi_slave_rx_if bus_m ();
  spi_slave_rx_if bus_l ();

  assign bus_m.sclk = sclk;
  assign bus_m.mosi = mosi;
  assign bus_m.cs_n = cs_m_n;
  assign bus_m.fifo_full = fifo_full;
  assign bus_m.ovf_clr = ovf_clr;
  assign bus_l.sclk = sclk;
  assign bus_l.mosi = mosi;
  assign bus_l.cs_n = cs_l_n;
  assign bus_l.fifo_full = fifo_full;
  assign bus_l.ovf_clr = ovf_clr;

  spi_slave_rx #(.SYNC_STAGES(SYNC), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst(rst), .bus(bus_m.slave));
  spi_slave_rx #(.SYNC_STAGES(SYNC), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(bus_l.slave));

  int checks = 0;
  int failures = 0;

  logic [7:0]  wr_m_q[$];
  logic [7:0]  wr_l_q[$];
  int          done_cnt[2];
  int          err_cnt[2];
  logic [15:0] fb_last[2];
  bit          ovf_model[2];

  logic [7:0] tx_bytes[16];
  bit         tx_full[16];
  int         tx_n;
  int         tx_partial;
  logic [7:0] tx_pbyte;

  always @(negedge clk) begin
    if (bus_m.fifo_write) wr_m_q.push_back(bus_m.fifo_wdata);
    if (bus_l.fifo_write) wr_l_q.push_back(bus_l.fifo_wdata);
    if (bus_m.frame_done) begin done_cnt[0]++; fb_last[0] = bus_m.frame_bytes; end
    if (bus_l.frame_done) begin done_cnt[1]++; fb_last[1] = bus_l.frame_bytes; end
    if (bus_m.frame_err) err_cnt[0]++;
    if (bus_l.frame_err) err_cnt[1]++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_capture();
    wr_m_q.delete();
    wr_l_q.delete();
    done_cnt[0] = 0; done_cnt[1] = 0;
    err_cnt[0] = 0;  err_cnt[1] = 0;
  endtask

  // One SPI bit; clr_hook pulses ovf_clr in the cycle the receiver acts on this rising edge.
  task automatic send_bit(input logic b, input bit clr_hook);
    mosi = b;
    repeat (HALF) @(negedge clk);
    sclk = 1'b1;
    if (clr_hook) begin
      repeat (SYNC) @(negedge clk);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      repeat (HALF - SYNC - 1) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
    sclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v, input bit lsb, input bit clr_last);
    for (int k = 0; k < 8; k++)
      send_bit(lsb ? v[k] : v[7-k], clr_last && (k == 7));
  endtask

  task automatic run_frame(input bit lsb, input bit clr_hook);
    clear_capture();
    if (clr_hook) begin ovf_model[0] = 1'b0; ovf_model[1] = 1'b0; end
    if (lsb) cs_l_n = 1'b0; else cs_m_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < tx_n; i++) begin
      fifo_full = tx_full[i];
      send_byte(tx_bytes[i], lsb, clr_hook && (i == tx_n - 1));
    end
    fifo_full = 1'b0;
    for (int k = 0; k < tx_partial; k++)
      send_bit(lsb ? tx_pbyte[k] : tx_pbyte[7-k], 1'b0);
    repeat (HALF) @(negedge clk);
    if (lsb) cs_l_n = 1'b1; else cs_m_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  // Frame model: every non-dropped byte is written in order, every full byte counts.
  task automatic check_frame(input string tag, input bit lsb);
    logic [7:0] exp_q[$];
    logic [7:0] got[$];
    int idx;
    idx = lsb ? 1 : 0;
    for (int i = 0; i < tx_n; i++) begin
      if (tx_full[i]) ovf_model[idx] = 1'b1;
      else exp_q.push_back(tx_bytes[i]);
    end
    if (lsb) got = wr_l_q; else got = wr_m_q;
    check({tag, ".nwr"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check($sformatf("%s.wdata%0d", tag, i), got[i], exp_q[i]);
    check({tag, ".done"}, done_cnt[idx], 1);
    check({tag, ".bytes"}, fb_last[idx], tx_n);
    check({tag, ".err"}, err_cnt[idx], (tx_partial != 0) ? 1 : 0);
    check({tag, ".ovf"}, lsb ? bus_l.overflow : bus_m.overflow, ovf_model[idx]);
    if (lsb) check({tag, ".wdhold"}, bus_l.fifo_wdata, bus_l.fifo_wdata);
    $display("frame %s lsb=%0d n=%0d partial=%0d writes=%0d", tag, lsb, tx_n, tx_partial, got.size());
  endtask

  task automatic set_frame1(input logic [7:0] b0, input int partial);
    tx_n = 1; tx_bytes[0] = b0; tx_full[0] = 1'b0; tx_partial = partial;
  endtask

  initial begin
    clear_capture();
    fb_last[0] = '0; fb_last[1] = '0;
    ovf_model[0] = 1'b0; ovf_model[1] = 1'b0;
    tx_pbyte = 8'h00;

    // Reset values
    repeat (4) @(negedge clk);
    check("rst.state", bus_m.diag_state, 2);
    check("rst.fifo_write", bus_m.fifo_write, 0);
    check("rst.wdata", bus_m.fifo_wdata, 0);
    check("rst.ovf", bus_m.overflow, 0);
    check("rst.done", bus_m.frame_done, 0);
    check("rst.err", bus_m.frame_err, 0);
    check("rst.bytes", bus_m.frame_bytes, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("idle.state_m", bus_m.diag_state, 0);
    check("idle.state_l", bus_l.diag_state, 0);

    // Single byte 0xA5
    set_frame1(8'hA5, 0);
    run_frame(1'b0, 1'b0);
    check_frame("a5", 1'b0);
    check("a5.wdhold", bus_m.fifo_wdata, 8'hA5);

    // Three bytes in one frame
    tx_n = 3; tx_partial = 0;
    tx_bytes[0] = 8'h01; tx_bytes[1] = 8'h02; tx_bytes[2] = 8'h03;
    tx_full[0] = 1'b0; tx_full[1] = 1'b0; tx_full[2] = 1'b0;
    run_frame(1'b0, 1'b0);
    check_frame("three", 1'b0);

    // Partial byte: 5 bits only
    tx_n = 0; tx_partial = 5; tx_pbyte = 8'hD7;
    run_frame(1'b0, 1'b0);
    check_frame("partial", 1'b0);

    // Second byte dropped on a full FIFO
    tx_n = 3; tx_partial = 0;
    tx_bytes[0] = 8'h11; tx_bytes[1] = 8'h22; tx_bytes[2] = 8'h33;
    tx_full[0] = 1'b0; tx_full[1] = 1'b1; tx_full[2] = 1'b0;
    run_frame(1'b0, 1'b0);
    check_frame("drop", 1'b0);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    ovf_model[0] = 1'b0; ovf_model[1] = 1'b0;
    @(negedge clk);
    check("ovf_clr", bus_m.overflow, 0);

    // Clear coinciding with a new drop: the drop wins
    tx_n = 1; tx_partial = 0; tx_bytes[0] = 8'h44; tx_full[0] = 1'b1;
    run_frame(1'b0, 1'b1);
    check_frame("clr_vs_set", 1'b0);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    ovf_model[0] = 1'b0; ovf_model[1] = 1'b0;

    // Reset mid-byte with cs_n held low through release
    clear_capture();
    cs_m_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int k = 0; k < 4; k++) send_bit(1'b1, 1'b0);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst.state0", bus_m.diag_state, 2);
    for (int k = 0; k < 12; k++) send_bit(1'b1, 1'b0);
    repeat (HALF) @(negedge clk);
    check("midrst.state1", bus_m.diag_state, 2);
    check("midrst.nwr", wr_m_q.size(), 0);
    check("midrst.done", done_cnt[0], 0);
    cs_m_n = 1'b1;
    repeat (12) @(negedge clk);
    check("midrst.idle", bus_m.diag_state, 0);
    set_frame1(8'h3C, 0);
    run_frame(1'b0, 1'b0);
    check_frame("after_rst", 1'b0);

    // LSB-first instance
    set_frame1(8'h81, 0);
    run_frame(1'b1, 1'b0);
    check_frame("lsb81", 1'b1);

    // sclk toggling with both chip selects high
    clear_capture();
    for (int k = 0; k < 16; k++) send_bit(1'($urandom_range(0, 1)), 1'b0);
    repeat (HALF) @(negedge clk);
    check("cs_hi.nwr_m", wr_m_q.size(), 0);
    check("cs_hi.nwr_l", wr_l_q.size(), 0);
    check("cs_hi.done_m", done_cnt[0], 0);
    check("cs_hi.done_l", done_cnt[1], 0);

    // Randomized frames on both instances
    for (int f = 0; f < 6; f++) begin
      bit lsb;
      lsb = (f >= 3);
      tx_n = $urandom_range(1, 3);
      for (int i = 0; i < tx_n; i++) begin
        tx_bytes[i] = 8'($urandom);
        tx_full[i] = ($urandom_range(0, 3) == 0);
      end
      tx_partial = $urandom_range(0, 7);
      tx_pbyte = 8'($urandom);
      run_frame(lsb, 1'b0);
      check_frame($sformatf("rnd%0d", f), lsb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
